// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared widths and command record for the on-chip memory arbiter
package onchip_mem_pkg;

    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
        logic                  we;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over N requesters with a rotating priority pointer
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam logic [IDX_W:0]   N_W   = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to rr_ptr so the nearest requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            cand = sum[IDX_W-1:0];
            if (advance && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant = grant_valid ? (N'(1) << grant_idx) : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin share of one single-port RAM among Avalon-MM masters
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int BE_W        = MEM_BE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          hold,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [BE_W-1:0]               mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic                   advance;
    mem_cmd_t               cmd;

    logic             rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0] rd_id_q, rd_id_d;

    assign req     = m_read | m_write;
    // Grant is combinational, so reset must also suppress it while reset_n is low.
    assign advance = reset_n & ~hold;

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .advance     (advance),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        cmd.we    = m_write[grant_idx];
        cmd.addr  = m_address[int'(grant_idx)*ADDR_W +: ADDR_W];
        cmd.be    = cmd.we ? m_byteenable[int'(grant_idx)*BE_W +: BE_W] : '1;
        cmd.wdata = m_writedata[int'(grant_idx)*DATA_W +: DATA_W];
    end

    assign mem_chipselect = grant_valid;
    assign mem_write      = grant_valid & cmd.we;
    assign mem_address    = cmd.addr;
    assign mem_byteenable = cmd.be;
    assign mem_writedata  = cmd.wdata;
    assign mem_clken      = ~hold;
    assign m_waitrequest  = ~grant;
    assign m_readdata     = mem_readdata;

    always_comb begin
        rd_pend_d = grant_valid & ~cmd.we;
        rd_id_d   = rd_pend_d ? grant_idx : rd_id_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    always_comb begin
        m_readdatavalid = '0;
        if (rd_pend_q) begin
            m_readdatavalid[rd_id_q] = 1'b1;
        end
    end

endmodule
